// File: rtl/gcd_host_ctrl.sv
// Host-side initiator for the GCD CPU host port.
// Takes one operand pair per job over a valid/ready request channel, writes the
// operands to the CPU, pulses start, follows the bsy handshake and returns the
// answer (or an abort indication) over a valid/ready response channel.
// Operand pairs containing a zero are answered locally without using the CPU.
module gcd_host_ctrl #(
   parameter logic [31:0] OPND_ADDR      = 32'h4000_0400,
   parameter int          ACK_LIMIT      = 4,
   parameter int          TIMEOUT_CYCLES = 4096,
   parameter int          CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_gcd,
   output logic             rsp_err,
   output logic [CNT_W-1:0] rsp_cycles,
   output logic             cpu_start,
   output logic             cpu_wen,
   output logic [31:0]      cpu_haddr,
   output logic [31:0]      cpu_hdin1,
   output logic [31:0]      cpu_hdin2,
   input  logic             cpu_bsy,
   input  logic [31:0]      cpu_gcd
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      ACK   = 3'd3,
      RUN   = 3'd4,
      RESP  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] ACK_LIMIT_C = CNT_W'(ACK_LIMIT);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t            state_reg,      state_next;
   logic [CNT_W-1:0]  cnt_reg,        cnt_next;
   logic              cpu_start_reg,  cpu_start_next;
   logic              cpu_wen_reg,    cpu_wen_next;
   logic [31:0]       haddr_reg,      haddr_next;
   logic [31:0]       hdin1_reg,      hdin1_next;
   logic [31:0]       hdin2_reg,      hdin2_next;
   logic              rsp_valid_reg,  rsp_valid_next;
   logic [31:0]       rsp_gcd_reg,    rsp_gcd_next;
   logic              rsp_err_reg,    rsp_err_next;
   logic [CNT_W-1:0]  rsp_cycles_reg, rsp_cycles_next;

   // Counter value including the current ACK/RUN cycle; sticks at all-ones.
   logic [CNT_W-1:0]  cnt_inc;
   logic              zero_opnd;

   assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
   assign zero_opnd = (req_a == 32'd0) || (req_b == 32'd0);

   // State and every registered output; asynchronous clear puts the block idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         cpu_start_reg  <= 1'b0;
         cpu_wen_reg    <= 1'b0;
         haddr_reg      <= 32'd0;
         hdin1_reg      <= 32'd0;
         hdin2_reg      <= 32'd0;
         rsp_valid_reg  <= 1'b0;
         rsp_gcd_reg    <= 32'd0;
         rsp_err_reg    <= 1'b0;
         rsp_cycles_reg <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         cpu_start_reg  <= cpu_start_next;
         cpu_wen_reg    <= cpu_wen_next;
         haddr_reg      <= haddr_next;
         hdin1_reg      <= hdin1_next;
         hdin2_reg      <= hdin2_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_gcd_reg    <= rsp_gcd_next;
         rsp_err_reg    <= rsp_err_next;
         rsp_cycles_reg <= rsp_cycles_next;
      end
   end

   // Next state plus the output values that belong to that next state (Moore, registered).
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      cpu_start_next  = 1'b0;
      cpu_wen_next    = 1'b0;
      haddr_next      = haddr_reg;
      hdin1_next      = hdin1_reg;
      hdin2_next      = hdin2_reg;
      rsp_valid_next  = rsp_valid_reg;
      rsp_gcd_next    = rsp_gcd_reg;
      rsp_err_next    = rsp_err_reg;
      rsp_cycles_next = rsp_cycles_reg;

      case (state_reg)
         IDLE: begin
            rsp_valid_next = 1'b0;
            if (req_valid) begin
               // Operands are latched here and stay put until the job is back in IDLE.
               hdin1_next = req_a;
               hdin2_next = req_b;
               if (zero_opnd) begin
                  // gcd(x,0) = x and gcd(0,0) is reported as 0, so OR gives the answer.
                  state_next      = RESP;
                  rsp_valid_next  = 1'b1;
                  rsp_gcd_next    = req_a | req_b;
                  rsp_err_next    = 1'b0;
                  rsp_cycles_next = '0;
               end else begin
                  state_next   = LOAD;
                  cpu_wen_next = 1'b1;
                  haddr_next   = OPND_ADDR;
               end
            end
         end

         LOAD: begin
            state_next     = START;
            cpu_start_next = 1'b1;
            haddr_next     = 32'd0;
         end

         START: begin
            state_next = ACK;
            cnt_next   = '0;
         end

         ACK: begin
            cnt_next = cnt_inc;
            // bsy is checked first so an acknowledge on the limit cycle still succeeds.
            if (cpu_bsy) begin
               state_next = RUN;
            end else if (cnt_inc == ACK_LIMIT_C) begin
               state_next      = RESP;
               rsp_valid_next  = 1'b1;
               rsp_gcd_next    = 32'd0;
               rsp_err_next    = 1'b1;
               rsp_cycles_next = cnt_inc;
            end
         end

         RUN: begin
            cnt_next = cnt_inc;
            // Completion wins over timeout. The abort fires once the counter already
            // holds TIMEOUT_CYCLES, so bsy may be high for TIMEOUT_CYCLES+1 cycles in total.
            if (!cpu_bsy) begin
               state_next      = RESP;
               rsp_valid_next  = 1'b1;
               rsp_gcd_next    = cpu_gcd;
               rsp_err_next    = 1'b0;
               rsp_cycles_next = cnt_inc;
            end else if (cnt_reg == TIMEOUT_C) begin
               state_next      = RESP;
               rsp_valid_next  = 1'b1;
               rsp_gcd_next    = 32'd0;
               rsp_err_next    = 1'b1;
               rsp_cycles_next = cnt_inc;
            end
         end

         RESP: begin
            // Result fields are held; only the handshake moves the FSM on.
            if (rsp_ready) begin
               state_next     = IDLE;
               rsp_valid_next = 1'b0;
            end
         end

         default: begin
            state_next     = IDLE;
            rsp_valid_next = 1'b0;
         end
      endcase
   end

   assign req_ready  = (state_reg == IDLE);
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_gcd    = rsp_gcd_reg;
   assign rsp_err    = rsp_err_reg;
   assign rsp_cycles = rsp_cycles_reg;
   assign cpu_start  = cpu_start_reg;
   assign cpu_wen    = cpu_wen_reg;
   assign cpu_haddr  = haddr_reg;
   assign cpu_hdin1  = hdin1_reg;
   assign cpu_hdin2  = hdin2_reg;

endmodule
